logic_unit_pipe: RTL and testbench

//   Parametrised, buffered successor to the 8-bit AND/OR/NOT unit.

---
 rtl/logic_unit_pkg.sv | 34 +++
 rtl/logic_unit_pipe_if.sv | 30 +++
 rtl/lu_fifo.sv | 55 +++++
 rtl/logic_unit_pipe.sv | 54 +++++
 tb/tb_logic_unit_pipe.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/logic_unit_pkg.sv
// Shared op codes and the bitwise evaluation function for logic_unit_pipe.
package logic_unit_pkg;

  // Widest operand lu_eval handles. Callers zero-extend into it and truncate the result.
  localparam int LU_MAX_W = 64;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NOT  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_XNOR = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  // All ops are bitwise, so the upper bits a caller discards never affect its low bits.
  function automatic logic [LU_MAX_W-1:0] lu_eval(input logic [LU_MAX_W-1:0] a,
                                                  input logic [LU_MAX_W-1:0] b,
                                                  input logic [2:0]          ctrl);
    logic [LU_MAX_W-1:0] r;
    case (ctrl)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NOT:  r = ~a;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      default: r = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Request/response bundle for logic_unit_pipe: input valid/ready, output valid/ready.
interface logic_unit_pipe_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       ctrl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             zero;
  logic [CW-1:0]    count;

  // Producer/consumer side of the unit.
  modport master (
    output in_valid, a, b, ctrl, out_ready,
    input  in_ready, out_valid, s, zero, count
  );

  // The unit itself.
  modport slave (
    input  in_valid, a, b, ctrl, out_ready,
    output in_ready, out_valid, s, zero, count
  );
endinterface

// File: rtl/lu_fifo.sv
// Small synchronous FIFO holding {zero, result} entries with an occupancy counter.
module lu_fifo #(
  parameter  int W     = 9,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_din,
  output logic [W-1:0]  o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rptr];

  // Storage, pointers and occupancy; reset clears everything so stale entries never reappear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_din;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Bitwise logic unit with a buffered output: op decode, zero detect, handshake glue.
// WIDTH is limited to LU_MAX_W (64) bits by the shared evaluation function.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input logic              clk,
  input logic              rst,
  logic_unit_pipe_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] w_res;
  logic             w_zero;
  logic [WIDTH:0]   w_head;
  logic             w_full;
  logic             w_empty;
  logic [CW-1:0]    w_count;
  logic             w_push;
  logic             w_pop;

  assign w_res  = WIDTH'(lu_eval(LU_MAX_W'(bus.a), LU_MAX_W'(bus.b), bus.ctrl));
  assign w_zero = (w_res == '0);

  // A full FIFO still accepts when the consumer drains the head this cycle.
  assign bus.in_ready  = ~w_full | bus.out_ready;
  assign w_push        = bus.in_valid & bus.in_ready;
  assign w_pop         = bus.out_valid & bus.out_ready;

  // Outputs come only from registered FIFO state; s/zero read 0 whenever empty (incl. reset).
  assign bus.out_valid = ~w_empty;
  assign bus.s         = w_empty ? '0 : w_head[WIDTH-1:0];
  assign bus.zero      = ~w_empty & w_head[WIDTH];
  assign bus.count     = w_count;

  lu_fifo #(
    .W     (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   ({w_zero, w_res}),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: 8-bit/2-deep and 16-bit/4-deep instances.
module tb_logic_unit_pipe;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic_unit_pipe_if #(.WIDTH(8),  .DEPTH(2)) bus8 ();
  logic_unit_pipe_if #(.WIDTH(16), .DEPTH(4)) bus16 ();

  logic_unit_pipe #(.WIDTH(8), .DEPTH(2)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  logic_unit_pipe #(.WIDTH(16), .DEPTH(4)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0] ctrl;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic       z;
  } vec_t;

  vec_t        vecs [13];
  logic [15:0] q [$];
  logic [15:0] v16;

  initial begin
    vecs[0]  = '{3'b000, 8'h05, 8'h03, 8'h01, 1'b0};
    vecs[1]  = '{3'b001, 8'h05, 8'h03, 8'h07, 1'b0};
    vecs[2]  = '{3'b010, 8'h05, 8'h03, 8'hFA, 1'b0};
    vecs[3]  = '{3'b011, 8'h05, 8'h03, 8'h06, 1'b0};
    vecs[4]  = '{3'b100, 8'h05, 8'h03, 8'hFE, 1'b0};
    vecs[5]  = '{3'b101, 8'h05, 8'h03, 8'hF8, 1'b0};
    vecs[6]  = '{3'b110, 8'h05, 8'h03, 8'hF9, 1'b0};
    vecs[7]  = '{3'b111, 8'h05, 8'h03, 8'h03, 1'b0};
    vecs[8]  = '{3'b000, 8'h05, 8'hFA, 8'h00, 1'b1};
    vecs[9]  = '{3'b101, 8'h05, 8'hFA, 8'h00, 1'b1};
    vecs[10] = '{3'b010, 8'hFF, 8'h12, 8'h00, 1'b1};
    vecs[11] = '{3'b110, 8'h5A, 8'hA5, 8'h00, 1'b1};
    vecs[12] = '{3'b111, 8'h77, 8'h00, 8'h00, 1'b1};

    rst = 1'b1;
    bus8.in_valid = 1'b0;  bus8.a = '0;  bus8.b = '0;  bus8.ctrl = '0;  bus8.out_ready = 1'b0;
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.ctrl = '0; bus16.out_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_count", bus8.count, 0);
    chk("rst_out_valid", bus8.out_valid, 0);
    chk("rst_in_ready", bus8.in_ready, 1);
    chk("rst_s", bus8.s, 0);
    chk("rst_zero", bus8.zero, 0);
    #6 rst = 1'b0;
    step();

    // Tests 1/2: all ops and zero flag, streaming with out_ready=1
    bus8.out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      bus8.in_valid = 1'b1;
      bus8.a    = vecs[i].a;
      bus8.b    = vecs[i].b;
      bus8.ctrl = vecs[i].ctrl;
      step();
      chk($sformatf("vec%0d_s", i), bus8.s, vecs[i].s);
      chk($sformatf("vec%0d_zero", i), bus8.zero, vecs[i].z);
      chk($sformatf("vec%0d_valid", i), bus8.out_valid, 1);
      chk($sformatf("vec%0d_count", i), bus8.count, 1);
    end
    bus8.in_valid = 1'b0;
    step();
    chk("stream_end_count", bus8.count, 0);
    chk("stream_end_valid", bus8.out_valid, 0);

    // Test 3: backpressure
    bus8.out_ready = 1'b0;
    bus8.in_valid = 1'b1; bus8.a = 8'h11; bus8.b = 8'h22; bus8.ctrl = 3'b001;
    #1 chk("bp_ready0", bus8.in_ready, 1);
    step();
    chk("bp_count1", bus8.count, 1);
    chk("bp_head1", bus8.s, 8'h33);
    bus8.a = 8'hF0; bus8.b = 8'h0F; bus8.ctrl = 3'b011;
    step();
    chk("bp_count2", bus8.count, 2);
    chk("bp_head2", bus8.s, 8'h33);
    bus8.a = 8'h0C; bus8.b = 8'h0A; bus8.ctrl = 3'b000;
    #1 chk("bp_full_ready", bus8.in_ready, 0);
    step();
    chk("bp_held_count", bus8.count, 2);
    chk("bp_held_head", bus8.s, 8'h33);
    bus8.out_ready = 1'b1;
    #1 chk("bp_popready", bus8.in_ready, 1);
    step();
    chk("bp_pushpop_count", bus8.count, 2);
    chk("bp_pushpop_head", bus8.s, 8'hFF);
    bus8.in_valid = 1'b0;

    // Test 4: drain
    step();
    chk("drain_count1", bus8.count, 1);
    chk("drain_head", bus8.s, 8'h08);
    chk("drain_valid1", bus8.out_valid, 1);
    step();
    chk("drain_count0", bus8.count, 0);
    chk("drain_valid0", bus8.out_valid, 0);

    // Test 5: reset mid-stream
    bus8.out_ready = 1'b0;
    bus8.in_valid = 1'b1; bus8.a = 8'h00; bus8.b = 8'hAA; bus8.ctrl = 3'b111;
    step();
    bus8.b = 8'hBB;
    step();
    chk("pre_rst_count", bus8.count, 2);
    bus8.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", bus8.out_valid, 0);
    chk("mid_rst_count", bus8.count, 0);
    chk("mid_rst_s", bus8.s, 0);
    chk("mid_rst_in_ready", bus8.in_ready, 1);
    bus8.in_valid = 1'b1; bus8.b = 8'h55;
    step();
    chk("rst_write_blocked", bus8.count, 0);
    bus8.in_valid = 1'b0;
    #2 rst = 1'b0;
    step();
    chk("post_rst_count", bus8.count, 0);
    chk("post_rst_valid", bus8.out_valid, 0);
    bus8.in_valid = 1'b1; bus8.a = 8'h0F; bus8.b = 8'hF0; bus8.ctrl = 3'b001;
    bus8.out_ready = 1'b1;
    step();
    chk("post_rst_s", bus8.s, 8'hFF);
    chk("post_rst_count1", bus8.count, 1);
    bus8.in_valid = 1'b0;
    step();
    chk("post_rst_single", bus8.count, 0);
    chk("post_rst_single_valid", bus8.out_valid, 0);

    // Test 6: WIDTH=16 DEPTH=4, fill and wrap
    bus16.out_ready = 1'b0;
    bus16.in_valid = 1'b1; bus16.a = 16'hA5A5; bus16.b = 16'hFFFF; bus16.ctrl = 3'b110;
    step();
    q.push_back(16'hA5A5);
    chk("w16_xnor_s", bus16.s, 16'hA5A5);
    chk("w16_xnor_zero", bus16.zero, 0);
    chk("w16_count1", bus16.count, 1);
    for (int k = 1; k < 4; k++) begin
      v16 = 16'(16'h1000 + k);
      bus16.a = 16'h0000; bus16.b = v16; bus16.ctrl = 3'b111;
      #1 chk($sformatf("w16_fill_ready%0d", k), bus16.in_ready, 1);
      step();
      q.push_back(v16);
      chk($sformatf("w16_fill_count%0d", k), bus16.count, k + 1);
      chk($sformatf("w16_fill_head%0d", k), bus16.s, q[0]);
    end
    #1 chk("w16_full_ready", bus16.in_ready, 0);
    bus16.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      v16 = 16'(16'h2000 + k);
      bus16.b = v16;
      #1 chk($sformatf("w16_wrap_ready%0d", k), bus16.in_ready, 1);
      step();
      void'(q.pop_front());
      q.push_back(v16);
      chk($sformatf("w16_wrap_head%0d", k), bus16.s, q[0]);
      chk($sformatf("w16_wrap_count%0d", k), bus16.count, 4);
    end
    bus16.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      void'(q.pop_front());
      chk($sformatf("w16_drain_count%0d", k), bus16.count, 3 - k);
      if (q.size() > 0) chk($sformatf("w16_drain_head%0d", k), bus16.s, q[0]);
    end
    chk("w16_empty_valid", bus16.out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
